// File: rtl/led_tick_counter.sv
// Prescaled LED pattern generator: every TICK_DIV enabled cycles the LED
// register steps up, down, rotates or holds, and TICK pulses for one cycle.
module led_tick_counter #(
  parameter int TICK_DIV = 25000000,
  parameter int N_LED    = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             EN,
  input  logic             CLR,
  input  logic [1:0]       MODE,
  output logic [N_LED-1:0] LED,
  output logic             TICK
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    MODE_UP   = 2'b00,
    MODE_DOWN = 2'b01,
    MODE_ROT  = 2'b10,
    MODE_HOLD = 2'b11
  } mode_t;

  logic [PW-1:0]    presc;
  logic [N_LED-1:0] led_rot;
  logic [N_LED-1:0] led_next;
  logic             at_last;

  assign at_last = (presc == LAST);

  // An all-zero pattern would rotate forever as zero, so it seeds a single lit LED.
  generate
    if (N_LED == 1) begin : g_rot1
      assign led_rot = 1'b1;
    end else begin : g_rotn
      assign led_rot = (LED == '0) ? N_LED'(1) : {LED[N_LED-2:0], LED[N_LED-1]};
    end
  endgenerate

  always_comb begin
    led_next = LED;
    case (mode_t'(MODE))
      MODE_UP:   led_next = LED + N_LED'(1);
      MODE_DOWN: led_next = LED - N_LED'(1);
      MODE_ROT:  led_next = led_rot;
      MODE_HOLD: led_next = LED;
      default:   led_next = LED;
    endcase
  end

  // CLR outranks EN; EN=0 freezes counting but still drops TICK.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      presc <= '0;
      LED   <= '0;
      TICK  <= 1'b0;
    end else if (CLR) begin
      presc <= '0;
      LED   <= '0;
      TICK  <= 1'b0;
    end else if (EN) begin
      if (at_last) begin
        presc <= '0;
        TICK  <= 1'b1;
        LED   <= led_next;
      end else begin
        presc <= presc + PW'(1);
        TICK  <= 1'b0;
      end
    end else begin
      TICK <= 1'b0;
    end
  end

endmodule

// File: tb/tb_led_tick_counter.sv
// Directed bench for led_tick_counter: a TICK_DIV=4 instance for the main
// behaviour plus a TICK_DIV=1 instance sharing the same inputs.
module tb_led_tick_counter;

  logic       CLK;
  logic       RST_N;
  logic       EN;
  logic       CLR;
  logic [1:0] MODE;
  logic [3:0] led4;
  logic       tick4;
  logic [3:0] led1;
  logic       tick1;

  int checks = 0;
  int errors = 0;

  led_tick_counter #(.TICK_DIV(4), .N_LED(4)) u_dut (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .CLR(CLR), .MODE(MODE),
    .LED(led4), .TICK(tick4)
  );

  led_tick_counter #(.TICK_DIV(1), .N_LED(4)) u_div1 (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .CLR(CLR), .MODE(MODE),
    .LED(led1), .TICK(tick1)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // driver: advance n rising edges, then settle 1 time unit past the edge
  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // scoreboard point
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [3:0] exp_led, input logic exp_tick);
    check({tag, "_led"}, 32'(led4), 32'(exp_led));
    check({tag, "_tick"}, 32'(tick4), 32'(exp_tick));
  endtask

  logic [3:0] rot_exp [5] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};

  initial begin
    RST_N = 1'b1;
    EN    = 1'b0;
    CLR   = 1'b0;
    MODE  = 2'b00;
    #1 RST_N = 1'b0;
    #1 check_out("reset", 4'h0, 1'b0);
    #1 begin RST_N = 1'b1; EN = 1'b1; MODE = 2'b00; end

    // up count: ticks on edges 4, 8, ... ; 16th tick wraps to 0
    step(3); check_out("up_pre", 4'h0, 1'b0);
    step(1); check_out("up_t1", 4'h1, 1'b1);
    step(1); check_out("up_post", 4'h1, 1'b0);
    step(3); check_out("up_t2", 4'h2, 1'b1);
    step(56); check_out("up_t16_wrap", 4'h0, 1'b1);

    // down count from 0
    MODE = 2'b01;
    step(4); check_out("down_t1", 4'hF, 1'b1);
    step(4); check_out("down_t2", 4'hE, 1'b1);

    // mode changes between ticks only matter at the tick edge
    MODE = 2'b11;
    step(2); check_out("midmode_hold", 4'hE, 1'b0);
    MODE = 2'b01;
    step(2); check_out("midmode_down", 4'hD, 1'b1);
    MODE = 2'b11;
    step(4); check_out("hold_tick", 4'hD, 1'b1);

    // clear, then rotate marquee from zero
    CLR = 1'b1;
    step(1); check_out("clr", 4'h0, 1'b0);
    CLR = 1'b0; MODE = 2'b10;
    for (int i = 0; i < 5; i++) begin
      step(4); check_out($sformatf("rot_%0d", i), rot_exp[i], 1'b1);
    end

    // enable gap of 3 cycles with prescaler at 2
    step(2); check_out("gate_pre", 4'h1, 1'b0);
    EN = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1); check_out($sformatf("gate_gap_%0d", i), 4'h1, 1'b0);
    end
    EN = 1'b1;
    step(1); check_out("gate_resume", 4'h1, 1'b0);
    step(1); check_out("gate_tick", 4'h2, 1'b1);

    // clear wins over a coincident tick with LED=5
    CLR = 1'b1; step(1); CLR = 1'b0; MODE = 2'b00;
    step(20); check_out("cp_led5", 4'h5, 1'b1);
    step(3); check_out("cp_prelast", 4'h5, 1'b0);
    CLR = 1'b1;
    step(1); check_out("cp_clr", 4'h0, 1'b0);
    CLR = 1'b0;
    step(3); check_out("cp_wait", 4'h0, 1'b0);
    step(1); check_out("cp_tick", 4'h1, 1'b1);

    // asynchronous reset between edges while LED=9
    step(32); check_out("ar_led9", 4'h9, 1'b1);
    #2 RST_N = 1'b0;
    #1 check_out("ar_async", 4'h0, 1'b0);
    #1 RST_N = 1'b1;
    step(3); check_out("ar_no_partial", 4'h0, 1'b0);
    step(1); check_out("ar_first_tick", 4'h1, 1'b1);

    // TICK_DIV=1: tick every enabled edge, LED increments each edge
    RST_N = 1'b0;
    #1 begin
      check("div1_reset_led", 32'(led1), 32'h0);
      check("div1_reset_tick", 32'(tick1), 32'h0);
    end
    RST_N = 1'b1; MODE = 2'b00; EN = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step(1);
      check($sformatf("div1_led_%0d", i), 32'(led1), 32'(i));
      check($sformatf("div1_tick_%0d", i), 32'(tick1), 32'h1);
    end
    EN = 1'b0;
    step(1);
    check("div1_en0_tick", 32'(tick1), 32'h0);
    check("div1_en0_led", 32'(led1), 32'h5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_tick_counter.md
LED_TICK_COUNTER -- requirements
Module: led_tick_counter

Interface
REQ-001 SHALL have parameter TICK_DIV, default 25000000, meaning the number of enabled CLK cycles per LED update tick; legal range is >= 1.
REQ-002 SHALL have parameter N_LED, default 4, meaning the LED output width; legal range is 1..32.
REQ-003 SHALL have port CLK, input, 1 bit: the single clock, rising edge.
REQ-004 SHALL have port RST_N, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port EN, input, 1 bit: 1 advances the prescaler, 0 freezes all state.
REQ-006 SHALL have port CLR, input, 1 bit: synchronous clear of the prescaler and the LED pattern.
REQ-007 SHALL have port MODE, input, 2 bits: 00 binary up, 01 binary down, 10 rotate-left marquee, 11 hold.
REQ-008 SHALL have port LED, output, N_LED bits: registered display pattern.
REQ-009 SHALL have port TICK, output, 1 bit: registered one-cycle pulse marking each LED update.

Function
REQ-010 Prescaler SHALL be an internal counter sized to ceil(log2(TICK_DIV)) bits, minimum 1 bit, counting 0..TICK_DIV-1.
REQ-011 On a rising CLK edge with EN=1, CLR=0 and prescaler < TICK_DIV-1, the prescaler SHALL increment, TICK SHALL be 0, and LED SHALL hold.
REQ-012 On a rising CLK edge with EN=1, CLR=0 and prescaler == TICK_DIV-1, the following SHALL all happen on that same edge:
- prescaler wraps to 0;
- TICK goes to 1 for exactly one cycle;
- LED updates per MODE as sampled on that edge.
REQ-013 Tick period SHALL be exactly TICK_DIV enabled cycles; for TICK_DIV=1, TICK SHALL stay high and LED SHALL update on every enabled edge.
REQ-014 MODE=00: LED <= LED+1 modulo 2^N_LED, so all-ones wraps to 0.
REQ-015 MODE=01: LED <= LED-1 modulo 2^N_LED, so 0 wraps to all-ones.
REQ-016 MODE=10: LED <= {LED[N_LED-2:0], LED[N_LED-1]}; if LED is all zeros at the tick, LED SHALL load 1 (LSB set) instead; for N_LED=1, LED <= 1.
REQ-017 MODE=11: LED SHALL hold; the prescaler and TICK SHALL continue normally.
REQ-018 MODE changes between ticks SHALL have no effect until the next tick edge; there is no other MODE latency.
REQ-019 EN=0 SHALL freeze the prescaler and LED and force TICK to 0; when EN returns to 1, counting SHALL resume from the frozen prescaler value.
REQ-020 CLR=1 on a rising edge SHALL set the prescaler to 0, LED to 0 and TICK to 0, regardless of EN, MODE or a coincident tick; CLR SHALL take priority over EN.
REQ-021 LED and TICK SHALL be driven directly from flops, with no combinational path from any input to any output.
REQ-022 All state SHALL be clocked by CLK only; no derived or rippled clocks are permitted.

Reset
REQ-023 RST_N=0 SHALL asynchronously force the prescaler to 0, LED to 0 and TICK to 0, without requiring a CLK edge.
REQ-024 When RST_N deasserts, the first enabled rising edge SHALL take the prescaler from 0 to 1; with EN held high, the first TICK SHALL occur on the TICK_DIV-th edge.
REQ-025 Reset asserted mid-period or mid-tick SHALL discard all progress; no partial tick SHALL be produced after release.

Verification (TICK_DIV=4, N_LED=4 unless stated)
REQ-026 Up count: release reset, EN=1, MODE=00 -> TICK high after edges 4, 8, 12, ...; LED reads 1, 2, 3, ...; after the 16th tick LED=0.
REQ-027 Down and rotate:
- From LED=0, MODE=01 -> first tick LED=F, second tick LED=E.
- Then CLR, then MODE=10 -> successive ticks give LED=1, 2, 4, 8, 1.
REQ-028 Enable gating: EN=0 for 3 cycles when the prescaler is 2 -> the next TICK is delayed by exactly 3 cycles; LED and TICK=0 hold throughout the gap.
REQ-029 Clear priority: CLR=1 on the same edge a tick would fire, with LED=5 -> LED=0 and TICK=0; the next TICK comes 4 enabled edges later with LED=1.
REQ-030 Async reset: RST_N low between CLK edges while LED=9 -> LED=0 and TICK=0 before the next CLK edge; also run TICK_DIV=1 with MODE=00 -> TICK continuously 1 and LED increments on every edge.
